// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//  Shared definitions for the UART receive path.
//  Contents:
//   DATA_BITS             number of data bits per frame (8N1 framing)
//   DEFAULT_CLKS_PER_BIT  default oversampling ratio (system clocks per bit)
//   rx_state_t            receiver FSM state encoding
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 4;

    // Receiver states. WAIT_IDLE absorbs a framing error or a line break so
    // that a long low level is never mistaken for a fresh start bit.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_sync2.sv
// ---------------------------------------------------------------------------
// uart_sync2
//  Two-flop synchronizer that brings the asynchronous serial line into the
//  clk domain. Both flops reset to 1 so that the idle-high line does not look
//  like a start bit while reset is being released.
//  Ports:
//   clk    in   system clock
//   res_n  in   asynchronous active-low reset
//   d      in   asynchronous input
//   q      out  synchronized copy of d, two clk cycles later
// ---------------------------------------------------------------------------
module uart_sync2 (
    input  logic clk,
    input  logic res_n,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; the second gives it a full cycle to
    // settle before anything downstream looks at the value.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : uart_sync2

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//  UART receiver for 8N1 frames (1 start, 8 data bits LSB first, 1 stop).
//  The serial line is oversampled with clk; every bit is sampled once at its
//  centre. A correctly framed byte is presented on rx_byte together with a
//  single-cycle rdy strobe. Frames with a low stop bit are discarded.
//  Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit, integer >= 2
//  Ports:
//   clk      in   system clock, rising edge
//   res_n    in   asynchronous active-low reset
//   rx       in   serial line, idle high, asynchronous to clk
//   rx_byte  out  last correctly framed byte, bit0 = first data bit received
//   rdy      out  one-cycle pulse, rx_byte has just been updated
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 rdy
);

    // HALF is the floor of half a bit period: the distance from the detected
    // falling edge to the centre of the start bit.
    localparam int HALF   = CLKS_PER_BIT / 2;
    localparam int CNT_W  = $clog2(CLKS_PER_BIT) + 1;
    localparam int BIDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIDX_W-1:0] IDX_LAST  = BIDX_W'(DATA_BITS - 1);

    rx_state_t             state;
    logic [CNT_W-1:0]      cnt;
    logic [BIDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0]  shreg;
    logic                  rx_s;

    // Every decision below is taken on rx_s, never on the raw pin.
    uart_sync2 u_sync (
        .clk   (clk),
        .res_n (res_n),
        .d     (rx),
        .q     (rx_s)
    );

    // Receiver FSM with its counters, shift register and registered outputs.
    // cnt restarts from zero at every sample point, so from the start-bit
    // centre onwards each sample lands exactly one bit period later, i.e. in
    // the middle of the next bit. rdy defaults low every cycle and is only
    // raised on the single cycle after a good stop bit was seen.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            rx_byte <= '0;
            rdy     <= 1'b0;
        end else begin
            rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end

                // Re-check the line at the start-bit centre; a line that has
                // already returned high was only a glitch.
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Data arrives LSB first, so each new bit enters at the top
                // and the first one ends up in bit 0 after eight shifts.
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + BIDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Going straight back to IDLE after the stop-bit centre lets
                // a following start bit be caught without an idle gap.
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            rx_byte <= shreg;
                            rdy     <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            state <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Hold off until the line is released after a framing error
                // or break condition.
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//  Self-checking bench for uart_rx with CLKS_PER_BIT = 4 (clk period 2,
//  bit time 8). Frames are driven bit by bit on falling clock edges; the
//  byte each good frame should deliver is queued when the frame is sent and
//  compared when rdy pulses.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CLKS    = 4;
    // Pin-to-rdy latency in rising edges: 2 sync + HALF + 9 bits + 1 register.
    localparam int LATENCY = 2 + CLKS / 2 + 9 * CLKS + 1;

    logic       clk;
    logic       res_n;
    logic       rx;
    logic [7:0] rx_byte;
    logic       rdy;

    int errors;
    int checks;
    int cyc;
    int rdy_count;
    int rdy_cyc;
    int start_cyc;
    logic prev_rdy;
    logic [7:0] exp_q[$];

    uart_rx #(.CLKS_PER_BIT(CLKS)) dut (
        .clk     (clk),
        .res_n   (res_n),
        .rx      (rx),
        .rx_byte (rx_byte),
        .rdy     (rdy)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    // Free-running cycle counter used to timestamp start bits and rdy.
    always @(posedge clk) cyc = cyc + 1;

    // Scoreboard side: every rdy pulse must match the oldest queued byte and
    // must not follow a cycle in which rdy was already high.
    always @(negedge clk) begin
        if (res_n && rdy) begin
            rdy_count = rdy_count + 1;
            rdy_cyc   = cyc;
            checks = checks + 1;
            if (prev_rdy !== 1'b0) begin
                errors = errors + 1;
                $display("[TB] FAIL rdy_width: rdy high %0d cycles in a row, expected 1", 2);
            end
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("[TB] FAIL unexpected_rdy: got rx_byte=%h, expected no rdy", rx_byte);
            end else begin
                logic [7:0] exp;
                exp = exp_q.pop_front();
                if (rx_byte !== exp) begin
                    errors = errors + 1;
                    $display("[TB] FAIL rx_byte: got %h, expected %h", rx_byte, exp);
                end
            end
        end
        prev_rdy = rdy;
    end

    // Hold the line idle for n cycles.
    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CLKS) @(negedge clk);
    endtask

    // Send one frame; a good stop bit means the byte is expected on rx_byte.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        if (stop_bit) exp_q.push_back(data);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(stop_bit);
    endtask

    task automatic test_reset;
        rx    = 1'b1;
        res_n = 1'b0;
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (rdy !== 1'b0) begin
            errors = errors + 1;
            $display("[TB] FAIL reset_rdy: got %b, expected 0", rdy);
        end
        checks = checks + 1;
        if (rx_byte !== 8'h00) begin
            errors = errors + 1;
            $display("[TB] FAIL reset_byte: got %h, expected 00", rx_byte);
        end
        res_n = 1'b1;
        idle(6);
    endtask

    task automatic test_single_frame;
        int base;
        base = rdy_count;
        send_frame(8'h8C, 1'b1);
        idle(8);
        checks = checks + 1;
        if (rdy_count - base !== 1) begin
            errors = errors + 1;
            $display("[TB] FAIL single_pulses: got %0d, expected 1", rdy_count - base);
        end
        idle(20);
        checks = checks + 1;
        if (rx_byte !== 8'h8C) begin
            errors = errors + 1;
            $display("[TB] FAIL single_held: got %h, expected 8c", rx_byte);
        end
    endtask

    task automatic test_back_to_back;
        int base;
        base = rdy_count;
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        idle(8);
        checks = checks + 1;
        if (rdy_count - base !== 2) begin
            errors = errors + 1;
            $display("[TB] FAIL b2b_pulses: got %0d, expected 2", rdy_count - base);
        end
        checks = checks + 1;
        if (exp_q.size() !== 0) begin
            errors = errors + 1;
            $display("[TB] FAIL b2b_pending: got %0d, expected 0", exp_q.size());
        end
    endtask

    task automatic test_glitch;
        int base;
        base = rdy_count;
        rx = 1'b0;
        @(negedge clk);
        idle(12);
        checks = checks + 1;
        if (rdy_count - base !== 0) begin
            errors = errors + 1;
            $display("[TB] FAIL glitch_pulses: got %0d, expected 0", rdy_count - base);
        end
        checks = checks + 1;
        if (rx_byte !== 8'hAA) begin
            errors = errors + 1;
            $display("[TB] FAIL glitch_byte: got %h, expected aa", rx_byte);
        end
        send_frame(8'h3C, 1'b1);
        idle(8);
        checks = checks + 1;
        if (rdy_count - base !== 1) begin
            errors = errors + 1;
            $display("[TB] FAIL glitch_next: got %0d pulses, expected 1", rdy_count - base);
        end
    endtask

    task automatic test_framing_error;
        int base;
        base = rdy_count;
        send_frame(8'hA5, 1'b0);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        idle(16);
        checks = checks + 1;
        if (rdy_count - base !== 0) begin
            errors = errors + 1;
            $display("[TB] FAIL frame_err_pulses: got %0d, expected 0", rdy_count - base);
        end
        checks = checks + 1;
        if (rx_byte !== 8'h3C) begin
            errors = errors + 1;
            $display("[TB] FAIL frame_err_byte: got %h, expected 3c", rx_byte);
        end
        send_frame(8'h5A, 1'b1);
        idle(8);
        checks = checks + 1;
        if (rdy_count - base !== 1) begin
            errors = errors + 1;
            $display("[TB] FAIL frame_err_next: got %0d pulses, expected 1", rdy_count - base);
        end
    endtask

    task automatic test_reset_mid_frame;
        int base;
        base = rdy_count;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        rx    = 1'b1;
        res_n = 1'b0;
        repeat (2) @(negedge clk);
        checks = checks + 1;
        if (rdy !== 1'b0) begin
            errors = errors + 1;
            $display("[TB] FAIL midreset_rdy: got %b, expected 0", rdy);
        end
        checks = checks + 1;
        if (rx_byte !== 8'h00) begin
            errors = errors + 1;
            $display("[TB] FAIL midreset_byte: got %h, expected 00", rx_byte);
        end
        res_n = 1'b1;
        idle(60);
        checks = checks + 1;
        if (rdy_count - base !== 0) begin
            errors = errors + 1;
            $display("[TB] FAIL midreset_pulses: got %0d, expected 0", rdy_count - base);
        end
        send_frame(8'h81, 1'b1);
        idle(8);
        checks = checks + 1;
        if (rx_byte !== 8'h81) begin
            errors = errors + 1;
            $display("[TB] FAIL midreset_next: got %h, expected 81", rx_byte);
        end
    endtask

    task automatic test_latency;
        int base;
        int lat;
        base = rdy_count;
        idle(4);
        send_frame(8'hC3, 1'b1);
        idle(8);
        checks = checks + 1;
        if (rdy_count - base !== 1) begin
            errors = errors + 1;
            $display("[TB] FAIL latency_pulses: got %0d, expected 1", rdy_count - base);
        end
        lat = rdy_cyc - start_cyc;
        checks = checks + 1;
        if (lat < LATENCY - 1 || lat > LATENCY + 1) begin
            errors = errors + 1;
            $display("[TB] FAIL latency: got %0d cycles, expected %0d +/-1", lat, LATENCY);
        end
        checks = checks + 1;
        if (rdy !== 1'b0) begin
            errors = errors + 1;
            $display("[TB] FAIL latency_rdy_low: got %b, expected 0", rdy);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        cyc       = 0;
        rdy_count = 0;
        rdy_cyc   = 0;
        start_cyc = 0;
        prev_rdy  = 1'b0;
        rx        = 1'b1;
        res_n     = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_framing_error();
        test_reset_mid_frame();
        test_latency();
        checks = checks + 1;
        if (exp_q.size() !== 0) begin
            errors = errors + 1;
            $display("[TB] FAIL pending_bytes: got %0d, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_rx
